id_ex_pipe_reg: RTL

//  ID/EX pipeline register of the 5-stage RV32I core, with integrated load-use hazard detection.

---
 rtl/id_ex_pipe_reg_pkg.sv | 37 +++
 rtl/id_ex_pipe_reg_load_use_detect.sv | 26 ++
 rtl/id_ex_pipe_reg.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/id_ex_pipe_reg_pkg.sv
// Shared definitions for the ID/EX pipeline stage: ALU op codes, forwarding
// select codes and the control values that make up a pipeline bubble.
package id_ex_pipe_reg_pkg;

    localparam int XLEN_DEF   = 32;
    localparam int REG_AW_DEF = 5;

    typedef enum logic [3:0] {
        ALUOP_ADD  = 4'h0,
        ALUOP_SUB  = 4'h1,
        ALUOP_SLL  = 4'h2,
        ALUOP_SLT  = 4'h3,
        ALUOP_SLTU = 4'h4,
        ALUOP_XOR  = 4'h5,
        ALUOP_SRL  = 4'h6,
        ALUOP_SRA  = 4'h7,
        ALUOP_OR   = 4'h8,
        ALUOP_AND  = 4'h9,
        ALUOP_LUI  = 4'hA,
        ALUOP_NOP  = 4'hF
    } aluop_e;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;

    // A bubble must look like "no instruction" to every consumer downstream.
    localparam logic       BUBBLE_VALID     = 1'b0;
    localparam logic       BUBBLE_REG_WRITE = 1'b0;
    localparam logic       BUBBLE_MEM_READ  = 1'b0;
    localparam logic       BUBBLE_MEM_WRITE = 1'b0;
    localparam logic       BUBBLE_MEM_TO_REG = 1'b0;
    localparam logic       BUBBLE_ALU_SRC   = 1'b0;
    localparam logic       BUBBLE_BRANCH    = 1'b0;
    localparam logic [3:0] BUBBLE_ALUOP     = ALUOP_NOP;

endpackage

// File: rtl/id_ex_pipe_reg_load_use_detect.sv
// Combinational load-use hazard detection between the instruction in ID and a
// load held in the following stage register.
module load_use_detect #(
    parameter int REG_AW = 5
) (
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_uses_rs1,
    input  logic              id_uses_rs2,
    input  logic              ex_valid,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_rd,
    output logic              hz
);

    logic rs1_hit;
    logic rs2_hit;
    logic ex_is_load;

    assign ex_is_load = ex_valid & ex_mem_read & (ex_rd != '0);
    assign rs1_hit    = id_uses_rs1 & (id_rs1 == ex_rd);
    assign rs2_hit    = id_uses_rs2 & (id_rs2 == ex_rd);
    assign hz         = id_valid & ex_is_load & (rs1_hit | rs2_hit);

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with load-use stall, bubble insertion on stall or
// branch flush, WB write-through on operand capture, and saturating event counters.
module id_ex_pipe_reg
    import id_ex_pipe_reg_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int REG_AW = REG_AW_DEF,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_uses_rs1,
    input  logic              id_uses_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_regWrite,
    input  logic              id_memRead,
    input  logic              id_memWrite,
    input  logic              id_memToReg,
    input  logic              id_aluSrc,
    input  logic              id_branch,
    input  logic [3:0]        id_aluOp,
    input  logic              ex_flush,
    input  logic              wb_regWrite,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    output logic              ID_EX_valid,
    output logic [XLEN-1:0]   ID_EX_pc,
    output logic [XLEN-1:0]   ID_EX_rs1_data,
    output logic [XLEN-1:0]   ID_EX_rs2_data,
    output logic [XLEN-1:0]   ID_EX_imm,
    output logic [REG_AW-1:0] ID_EX_rs1,
    output logic [REG_AW-1:0] ID_EX_rs2,
    output logic [REG_AW-1:0] ID_EX_rd,
    output logic              ID_EX_regWrite,
    output logic              ID_EX_memRead,
    output logic              ID_EX_memWrite,
    output logic              ID_EX_memToReg,
    output logic              ID_EX_aluSrc,
    output logic              ID_EX_branch,
    output logic [3:0]        ID_EX_aluOp,
    output logic              stall,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    logic            hz;
    logic            load_bubble;
    logic            wb_live;
    logic [XLEN-1:0] rs1_capture;
    logic [XLEN-1:0] rs2_capture;

    load_use_detect #(
        .REG_AW (REG_AW)
    ) u_load_use_detect (
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .ex_valid    (ID_EX_valid),
        .ex_mem_read (ID_EX_memRead),
        .ex_rd       (ID_EX_rd),
        .hz          (hz)
    );

    // A flushed ID instruction is dead, so it must not hold the front end.
    assign stall       = hz & ~ex_flush;
    assign load_bubble = ex_flush | stall;

    assign wb_live = wb_regWrite & (wb_rd != '0);

    always_comb begin
        rs1_capture = id_rs1_data;
        rs2_capture = id_rs2_data;
        if (wb_live && (wb_rd == id_rs1)) begin
            rs1_capture = wb_data;
        end
        if (wb_live && (wb_rd == id_rs2)) begin
            rs2_capture = wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ID_EX_valid    <= 1'b0;
            ID_EX_pc       <= '0;
            ID_EX_rs1_data <= '0;
            ID_EX_rs2_data <= '0;
            ID_EX_imm      <= '0;
            ID_EX_rs1      <= '0;
            ID_EX_rs2      <= '0;
            ID_EX_rd       <= '0;
            ID_EX_regWrite <= 1'b0;
            ID_EX_memRead  <= 1'b0;
            ID_EX_memWrite <= 1'b0;
            ID_EX_memToReg <= 1'b0;
            ID_EX_aluSrc   <= 1'b0;
            ID_EX_branch   <= 1'b0;
            ID_EX_aluOp    <= 4'h0;
        end else if (load_bubble) begin
            // Register fields are zeroed too so forwarding can never match a bubble.
            ID_EX_valid    <= BUBBLE_VALID;
            ID_EX_pc       <= '0;
            ID_EX_rs1_data <= '0;
            ID_EX_rs2_data <= '0;
            ID_EX_imm      <= '0;
            ID_EX_rs1      <= '0;
            ID_EX_rs2      <= '0;
            ID_EX_rd       <= '0;
            ID_EX_regWrite <= BUBBLE_REG_WRITE;
            ID_EX_memRead  <= BUBBLE_MEM_READ;
            ID_EX_memWrite <= BUBBLE_MEM_WRITE;
            ID_EX_memToReg <= BUBBLE_MEM_TO_REG;
            ID_EX_aluSrc   <= BUBBLE_ALU_SRC;
            ID_EX_branch   <= BUBBLE_BRANCH;
            ID_EX_aluOp    <= BUBBLE_ALUOP;
        end else begin
            ID_EX_valid    <= id_valid;
            ID_EX_pc       <= id_pc;
            ID_EX_rs1_data <= rs1_capture;
            ID_EX_rs2_data <= rs2_capture;
            ID_EX_imm      <= id_imm;
            ID_EX_rs1      <= id_rs1;
            ID_EX_rs2      <= id_rs2;
            ID_EX_rd       <= id_rd;
            ID_EX_regWrite <= id_regWrite;
            ID_EX_memRead  <= id_memRead;
            ID_EX_memWrite <= id_memWrite;
            ID_EX_memToReg <= id_memToReg;
            ID_EX_aluSrc   <= id_aluSrc;
            ID_EX_branch   <= id_branch;
            ID_EX_aluOp    <= id_aluOp;
        end
    end

    // Flush takes priority, so a coincident stall request is not counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (ex_flush) begin
            if (flush_cnt != '1) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end else if (stall) begin
            if (stall_cnt != '1) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

endmodule
